// File: rtl/systolic_pkg.sv
// Shared definitions for the NOR systolic array sequencer.
//   state_e     : controller states (IDLE, LOAD, SETTLE, DONE)
//   DEF_*       : default array geometry, settle time and op-counter width
//   beat_count  : number of serial beats making up one operation
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEF_ROW    = 4;
  localparam int DEF_COLUMN = 10;
  localparam int DEF_SETTLE = 8;
  localparam int DEF_CW     = 8;

  // Rows come first on the wire, then columns; one bit per beat.
  function automatic int beat_count(input int row, input int column);
    return row + column;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Handshake bundle between the operand/result agent and the sequencer.
//   in_valid/in_ready/in_bit    : bit-serial operand stream
//   res_valid/res_ready/res_bit : one-bit result return
// master : the agent feeding operands and consuming results
// slave  : the sequencer
interface systolic_ctrl_if;

  logic in_valid;
  logic in_ready;
  logic in_bit;
  logic res_valid;
  logic res_ready;
  logic res_bit;

  modport master (
    output in_valid, in_bit, res_ready,
    input  in_ready, res_valid, res_bit
  );

  modport slave (
    input  in_valid, in_bit, res_ready,
    output in_ready, res_valid, res_bit
  );

endinterface

// File: rtl/systolic_ctrl_cnt.sv
// Loadable down-counter with zero flag.
//   clk, rst    : clock, synchronous active-high reset (clears to 0)
//   load_i      : load load_val_i (has priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one; saturates at zero
//   zero_o      : count is zero
module systolic_ctrl_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for a ROW x COLUMN NOR systolic array.
// Collects ROW+COLUMN operand bits from a bit-serial valid/ready stream
// (LSB first, rows before columns), applies them to the array in one
// atomic update, waits a programmable settle time, samples the array
// output and returns it over a result valid/ready handshake.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   strm       : operand stream and result handshake (slave side)
//   arr_row    : array row operands
//   arr_col    : array column operands
//   arr_out    : array output
//   busy       : high in every state except IDLE
//   op_count   : completed operations, wraps modulo 2^CW
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int ROW    = DEF_ROW,
  parameter int COLUMN = DEF_COLUMN,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CW     = DEF_CW
) (
  input  logic              clk,
  input  logic              rst,
  systolic_ctrl_if.slave    strm,
  output logic [ROW-1:0]    arr_row,
  output logic [COLUMN-1:0] arr_col,
  input  logic              arr_out,
  output logic              busy,
  output logic [CW-1:0]     op_count
);

  localparam int NB = beat_count(ROW, COLUMN);
  localparam int BW = $clog2(NB + 1);
  localparam int SW = $clog2(SETTLE + 1);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_LOAD   = ST_LOAD;
  localparam logic [1:0] S_SETTLE = ST_SETTLE;
  localparam logic [1:0] S_DONE   = ST_DONE;

  logic [1:0]        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              res_valid_q, res_valid_d;
  logic              res_bit_q, res_bit_d;
  logic [NB-1:0]     sr_q, sr_d;
  logic [NB-1:0]     sr_full;
  logic [ROW-1:0]    arr_row_q, arr_row_d;
  logic [COLUMN-1:0] arr_col_q, arr_col_d;
  logic [CW-1:0]     op_count_q, op_count_d;

  logic accept;
  logic hs;
  logic bcnt_load, bcnt_dec, bcnt_zero;
  logic scnt_load, scnt_dec, scnt_zero;

  assign accept = strm.in_valid & in_ready_q;
  assign hs     = res_valid_q & strm.res_ready;

  // Beats enter at the MSB and move down; after NB shifts beat k sits at
  // bit k, so the final beat plus the register is the whole operand word.
  assign sr_full = {strm.in_bit, sr_q[NB-1:1]};

  // Beats still expected after the current one. Loaded on the first beat
  // with NB-2, so the beat that finds it at zero is the last one.
  systolic_ctrl_cnt #(.W(BW)) u_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (bcnt_load),
    .load_val_i (BW'(NB - 2)),
    .dec_i      (bcnt_dec),
    .zero_o     (bcnt_zero)
  );

  // Loaded with SETTLE on the apply edge; the cycle that finds it at zero
  // is the sample cycle, giving SETTLE+1 edges from apply to res_valid.
  systolic_ctrl_cnt #(.W(SW)) u_settle_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (scnt_load),
    .load_val_i (SW'(SETTLE)),
    .dec_i      (scnt_dec),
    .zero_o     (scnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    arr_row_d   = arr_row_q;
    arr_col_d   = arr_col_q;
    res_valid_d = res_valid_q;
    res_bit_d   = res_bit_q;
    op_count_d  = op_count_q;
    bcnt_load   = 1'b0;
    bcnt_dec    = 1'b0;
    scnt_load   = 1'b0;
    scnt_dec    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          sr_d      = sr_full;
          bcnt_load = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          sr_d = sr_full;
          if (bcnt_zero) begin
            // Whole operand set reaches the array on this single edge.
            arr_row_d = sr_full[ROW-1:0];
            arr_col_d = sr_full[NB-1:ROW];
            scnt_load = 1'b1;
            state_d   = S_SETTLE;
          end else begin
            bcnt_dec = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (scnt_zero) begin
          res_bit_d   = arr_out;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          scnt_dec = 1'b1;
        end
      end
      S_DONE: begin
        if (hs) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered from the next state so in_ready has no path from in_valid
  // and reads low while rst is held.
  assign in_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_bit_q   <= 1'b0;
      sr_q        <= '0;
      arr_row_q   <= '0;
      arr_col_q   <= '0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_bit_q   <= res_bit_d;
      sr_q        <= sr_d;
      arr_row_q   <= arr_row_d;
      arr_col_q   <= arr_col_d;
      op_count_q  <= op_count_d;
    end
  end

  assign strm.in_ready  = in_ready_q;
  assign strm.res_valid = res_valid_q;
  assign strm.res_bit   = res_bit_q;
  assign arr_row        = arr_row_q;
  assign arr_col        = arr_col_q;
  assign busy           = (state_q != S_IDLE);
  assign op_count       = op_count_q;

endmodule
